// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: PS/2 device-to-host receiver.
// The raw clock and data lines are synchronised, and the clock is then
// glitch-filtered. Each 11-bit frame is deframed and checked for odd parity
// and the stop bit. For each good frame the block presents the scan code and
// the number of zero bits in it.
// Optional build macro PS2_RX_TIMEOUT_EN: aborts a frame that stalls mid-way.
module ps2_rx_frame #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic [3:0] number_of_zeros,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  if (SYNC_STAGES < 2 || FILTER_LEN < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("ps2_rx_frame: SYNC_STAGES >= 2, FILTER_LEN >= 1, TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                   clk_s, data_s;
  logic                   filt_q, fall_q;
  logic [CNT_W-1:0]       filt_cnt_q;

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic       par_q, par_d;
  logic [7:0] code_q, code_d;
  logic [3:0] nz_q, nz_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_q, to_d;
`endif

  // Zero bits in a byte (equivalently 8 minus the popcount), range 0..8.
  function automatic logic [3:0] count_zeros(input logic [7:0] b);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'd0, ~b[i]};
    return n;
  endfunction

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];

  // Synchronise both lines, filter the clock, and strobe on a filtered fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      filt_q      <= 1'b1;
      filt_cnt_q  <= '0;
      fall_q      <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      fall_q      <= 1'b0;
      if (clk_s != filt_q) begin
        if (filt_cnt_q == CNT_W'(FILTER_LEN - 1)) begin
          filt_q     <= clk_s;
          filt_cnt_q <= '0;
          fall_q     <= filt_q;
        end else begin
          filt_cnt_q <= filt_cnt_q + CNT_W'(1);
        end
      end else begin
        filt_cnt_q <= '0;
      end
    end
  end

  // Frame FSM and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bitcnt_q <= '0;
      par_q    <= 1'b0;
      code_q   <= '0;
      nz_q     <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
      to_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      par_q    <= par_d;
      code_q   <= code_d;
      nz_q     <= nz_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
`ifdef PS2_RX_TIMEOUT_EN
      to_q     <= to_d;
`endif
    end
  end

  // Next-state logic: advance one bit per fall strobe, judge the frame at STOP.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    par_d    = par_q;
    code_d   = code_q;
    nz_d     = nz_q;
    valid_d  = 1'b0;
    err_d    = err_q;
`ifdef PS2_RX_TIMEOUT_EN
    to_d = (fall_q || state_q == IDLE) ? '0 : to_q + TO_W'(1);
`endif
    if (fall_q) begin
      case (state_q)
        IDLE: begin
          if (!data_s) begin
            state_d  = DATA;
            bitcnt_d = 3'd0;
          end
        end
        DATA: begin
          shift_d  = {data_s, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = data_s;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (((^shift_q) ^ par_q) && data_s) begin
            code_d  = shift_q;
            nz_d    = count_zeros(shift_q);
            valid_d = 1'b1;
            err_d   = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
`ifdef PS2_RX_TIMEOUT_EN
    // A stalled frame is dropped; the timeout overrides a coincident strobe.
    if (state_q != IDLE && to_q == TO_W'(TIMEOUT_CYCLES)) begin
      state_d  = IDLE;
      shift_d  = '0;
      bitcnt_d = '0;
      valid_d  = 1'b0;
      err_d    = 1'b1;
      to_d     = '0;
    end
`endif
  end

  assign code            = code_q;
  assign number_of_zeros = nz_q;
  assign code_valid      = valid_q;
  assign frame_err       = err_q;

endmodule
